add_sub_cla_4bit: RTL and testbench

//   4-bit adder/subtractor built on a carry-lookahead (CLA) carry network, with registered outputs.
//   sel=0: sum = a + b.  sel=1: sum = a - b (two's complement: a + ~b + 1).

---
 rtl/add_sub_cla_4bit_pkg.sv | 6 +
 rtl/add_sub_cla_4bit_cla_core.sv | 39 +++
 rtl/add_sub_cla_4bit.sv | 44 ++++
 tb/tb_add_sub_cla_4bit.sv | 199 +++++++++++++++++++
 4 files changed

// File: rtl/add_sub_cla_4bit_pkg.sv
// Shared constants for the CLA adder/subtractor: operation select encoding and default width.
package add_sub_cla_4bit_pkg;
    localparam logic SEL_ADD = 1'b0;
    localparam logic SEL_SUB = 1'b1;
    localparam int   DEF_WIDTH = 4;
endpackage

// File: rtl/add_sub_cla_4bit_cla_core.sv
// Combinational carry-lookahead core: generate/propagate, flat sum-of-products carries, sum bits.
module cla_core #(
    parameter int WIDTH = 4
) (
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] bb,
    input  logic             cin,
    output logic [WIDTH-1:0] s,
    output logic [WIDTH:0]   c
);
    logic [WIDTH-1:0] g;
    logic [WIDTH-1:0] p;

    assign g = a & bb;
    assign p = a ^ bb;

    // Each c[i+1] is built only from g, p and cin, so no carry feeds another carry.
    always_comb begin
        logic prod;
        logic ci;
        c    = '0;
        prod = 1'b0;
        ci   = 1'b0;
        c[0] = cin;
        for (int i = 0; i < WIDTH; i++) begin
            prod = cin;
            for (int m = 0; m <= i; m++) prod = prod & p[m];
            ci = prod;
            for (int k = 0; k <= i; k++) begin
                prod = g[k];
                for (int m = k + 1; m <= i; m++) prod = prod & p[m];
                ci = ci | prod;
            end
            c[i+1] = ci;
        end
    end

    assign s = p ^ c[WIDTH-1:0];
endmodule

// File: rtl/add_sub_cla_4bit.sv
// Registered adder/subtractor: conditional b inversion with carry-in, CLA core, output flops.
module add_sub_cla_4bit
    import add_sub_cla_4bit_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             sel,
    output logic [WIDTH-1:0] sum,
    output logic             carry,
    output logic             overflow
);
    logic [WIDTH-1:0] bb;
    logic [WIDTH-1:0] s;
    logic [WIDTH:0]   c;
    logic             cin;

    // Subtract is a + ~b + 1: invert b and feed the +1 through the carry-in.
    assign bb  = b ^ {WIDTH{sel}};
    assign cin = (sel == SEL_SUB);

    cla_core #(.WIDTH(WIDTH)) u_cla (
        .a   (a),
        .bb  (bb),
        .cin (cin),
        .s   (s),
        .c   (c)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sum      <= '0;
            carry    <= 1'b0;
            overflow <= 1'b0;
        end else begin
            sum      <= s;
            carry    <= c[WIDTH];
            overflow <= c[WIDTH] ^ c[WIDTH-1];
        end
    end
endmodule

// File: tb/tb_add_sub_cla_4bit.sv
// Self-checking bench: directed boundary cases, back-to-back stream, mid-stream reset, exhaustive sweep.
module tb_add_sub_cla_4bit;
    logic       clk;
    logic       rst_n;
    logic [3:0] a;
    logic [3:0] b;
    logic       sel;
    logic [3:0] sum;
    logic       carry;
    logic       overflow;

    int vectors;
    int miscompares;

    add_sub_cla_4bit #(.WIDTH(4)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .a        (a),
        .b        (b),
        .sel      (sel),
        .sum      (sum),
        .carry    (carry),
        .overflow (overflow)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference: integer arithmetic for sum/carry, signed range test for overflow.
    function automatic logic [5:0] model(input logic [3:0] ma, input logic [3:0] mb, input logic msel);
        int beff, total, sa, sb, res;
        logic v;
        beff  = msel ? (15 - int'(mb)) : int'(mb);
        total = int'(ma) + beff + (msel ? 1 : 0);
        sa    = (ma >= 4'd8) ? int'(ma) - 16 : int'(ma);
        sb    = (mb >= 4'd8) ? int'(mb) - 16 : int'(mb);
        res   = msel ? sa - sb : sa + sb;
        v     = (res > 7) || (res < -8);
        return {(total % 16 == total) ? 1'b0 : 1'b1, 4'(total % 16), v};
    endfunction

    task automatic test_reset();
        logic [5:0] exp;
        rst_n = 1'b0;
        a = 4'($urandom); b = 4'($urandom); sel = 1'($urandom);
        #2;
        vectors++;
        if ({carry, sum, overflow} !== 6'b0) begin
            miscompares++;
            $display("FAIL reset_async got c=%b s=%b v=%b want 0/0000/0", carry, sum, overflow);
        end
        @(posedge clk); #1;
        vectors++;
        if ({carry, sum, overflow} !== 6'b0) begin
            miscompares++;
            $display("FAIL reset_held got c=%b s=%b v=%b want 0/0000/0", carry, sum, overflow);
        end
        @(negedge clk);
        rst_n = 1'b1;
        a = 4'd0; b = 4'd0; sel = 1'b0;
        @(posedge clk); #1;
        exp = 6'b000000;
        vectors++;
        if ({carry, sum, overflow} !== exp) begin
            miscompares++;
            $display("FAIL zero_add got %b want %b", {carry, sum, overflow}, exp);
        end
        sel = 1'b1;
        @(posedge clk); #1;
        exp = 6'b100000;
        vectors++;
        if ({carry, sum, overflow} !== exp) begin
            miscompares++;
            $display("FAIL zero_sub got %b want %b", {carry, sum, overflow}, exp);
        end
    endtask

    task automatic test_directed();
        // {a, b, sel, carry, sum, overflow}
        logic [14:0] tbl [6];
        tbl[0] = {4'b1000, 4'b0001, 1'b0, 1'b0, 4'b1001, 1'b0};
        tbl[1] = {4'b1000, 4'b0001, 1'b1, 1'b1, 4'b0111, 1'b1};
        tbl[2] = {4'b1010, 4'b0101, 1'b0, 1'b0, 4'b1111, 1'b0};
        tbl[3] = {4'b1010, 4'b0101, 1'b1, 1'b1, 4'b0101, 1'b1};
        tbl[4] = {4'b0010, 4'b1110, 1'b0, 1'b1, 4'b0000, 1'b0};
        tbl[5] = {4'b0010, 4'b1110, 1'b1, 1'b0, 4'b0100, 1'b0};
        for (int i = 0; i < 6; i++) begin
            a = tbl[i][14:11]; b = tbl[i][10:7]; sel = tbl[i][6];
            @(posedge clk); #1;
            vectors++;
            if ({carry, sum, overflow} !== tbl[i][5:0]) begin
                miscompares++;
                $display("FAIL directed_%0d got %b want %b", i, {carry, sum, overflow}, tbl[i][5:0]);
            end
        end
        // x - x and a - 0 rules with random operands
        for (int i = 0; i < 4; i++) begin
            a = 4'($urandom); b = a; sel = 1'b1;
            @(posedge clk); #1;
            vectors++;
            if ({carry, sum, overflow} !== 6'b100000) begin
                miscompares++;
                $display("FAIL x_minus_x a=%h got %b want 100000", a, {carry, sum, overflow});
            end
            b = 4'd0;
            @(posedge clk); #1;
            vectors++;
            if (carry !== 1'b1 || sum !== a) begin
                miscompares++;
                $display("FAIL a_minus_0 a=%h got c=%b s=%h want c=1 s=%h", a, carry, sum, a);
            end
        end
    endtask

    task automatic test_back_to_back();
        logic [5:0] exp_prev;
        logic [5:0] exp_cur;
        a = 4'($urandom); b = 4'($urandom); sel = 1'($urandom);
        exp_cur = model(a, b, sel);
        for (int i = 0; i < 24; i++) begin
            @(posedge clk); #1;
            vectors++;
            if ({carry, sum, overflow} !== exp_cur) begin
                miscompares++;
                $display("FAIL b2b_%0d got %b want %b", i, {carry, sum, overflow}, exp_cur);
            end
            exp_prev = exp_cur;
            a = 4'($urandom); b = 4'($urandom); sel = 1'($urandom);
            exp_cur = model(a, b, sel);
            #2;
            vectors++;
            if ({carry, sum, overflow} !== exp_prev) begin
                miscompares++;
                $display("FAIL b2b_hold_%0d got %b want %b", i, {carry, sum, overflow}, exp_prev);
            end
        end
    endtask

    task automatic test_mid_reset();
        logic [5:0] exp;
        a = 4'b0111; b = 4'b0001; sel = 1'b0;
        @(posedge clk); #1;
        a = 4'b1111; b = 4'b0001; sel = 1'b0;
        #2;
        rst_n = 1'b0;
        #1;
        vectors++;
        if ({carry, sum, overflow} !== 6'b0) begin
            miscompares++;
            $display("FAIL midreset_async got %b want 000000", {carry, sum, overflow});
        end
        @(posedge clk); #1;
        vectors++;
        if ({carry, sum, overflow} !== 6'b0) begin
            miscompares++;
            $display("FAIL midreset_discard got %b want 000000", {carry, sum, overflow});
        end
        @(negedge clk);
        rst_n = 1'b1;
        exp = model(a, b, sel);
        @(posedge clk); #1;
        vectors++;
        if ({carry, sum, overflow} !== exp) begin
            miscompares++;
            $display("FAIL midreset_resume got %b want %b", {carry, sum, overflow}, exp);
        end
    endtask

    task automatic test_exhaustive();
        logic [5:0] exp;
        for (int i = 0; i < 512; i++) begin
            logic [8:0] v;
            v = 9'(i);
            a = v[7:4]; b = v[3:0]; sel = v[8];
            exp = model(a, b, sel);
            @(posedge clk); #1;
            vectors++;
            if ({carry, sum, overflow} !== exp) begin
                miscompares++;
                $display("FAIL exhaustive a=%b b=%b sel=%b got c=%b s=%b v=%b want c=%b s=%b v=%b",
                         a, b, sel, carry, sum, overflow, exp[5], exp[4:1], exp[0]);
            end
        end
    endtask

    initial begin
        vectors = 0;
        miscompares = 0;
        rst_n = 1'b0;
        a = '0; b = '0; sel = 1'b0;
        test_reset();
        test_directed();
        test_back_to_back();
        test_mid_reset();
        test_exhaustive();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
